reset_ctrl: RTL and testbench

- System reset generator sitting directly downstream of the watchdog.
- Inputs: raw power-on/pin reset, the watchdog reset pulse, and a software reset request written over the memory map.
- Output: one stretched, clock-synchronous system reset (o_sysRstn) for the rest of the processor, including the watchdog itself.
- Latches the reset cause and a saturating watchdog-reset count, both readable by SW after reboot and not cleared by o_sysRstn.

---
 rtl/reset_ctrl_pkg.sv | 32 +++
 rtl/reset_sync.sv | 22 ++
 rtl/reset_ctrl.sv | 148 ++++++++++++++
 tb/tb_reset_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the system reset generator: memory-map offsets,
// cause bit positions, FSM encoding and the watchdog reset counter helper.
package reset_ctrl_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_CTRL   = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  localparam int CAUSE_POR   = 0;
  localparam int CAUSE_WDT   = 1;
  localparam int CAUSE_SW    = 2;
  localparam int CTRL_SW_BIT = 0;

  localparam int WDT_CNT_W = 8;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Increment that sticks at all-ones so the count never wraps back to zero.
  function automatic logic [WDT_CNT_W-1:0] satInc(input logic [WDT_CNT_W-1:0] value);
    logic [WDT_CNT_W-1:0] one;
    one = {{(WDT_CNT_W-1){1'b0}}, 1'b1};
    if (value == {WDT_CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + one;
    end
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously with i_rstn and
// releases two i_clk edges after i_rstn goes high.
module reset_sync (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_syncRstn
);

  logic [1:0] rstnSync_r;

  // Shift a one through the chain; any i_rstn low clears both stages at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rstnSync_r <= 2'b00;
    end else begin
      rstnSync_r <= {rstnSync_r[0], 1'b1};
    end
  end

  assign o_syncRstn = rstnSync_r[1];

endmodule

// File: rtl/reset_ctrl.sv
// System reset generator: stretches POR, watchdog and software resets into
// o_sysRstn and keeps a sticky cause register. Define RSTCTRL_WDT_COUNT_EN to add the watchdog reset counter.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wdtReset,
  input  logic [1:0]  i_memAddr,
  input  logic [15:0] i_memDataIn,
  input  logic        i_memWrEn,
  output logic [15:0] o_memDataOut,
  output logic        o_sysRstn
);

  localparam int CNT_W = (HOLD_CYCLES <= 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             syncRstn_s;
  state_t           state_r;
  logic [CNT_W-1:0] holdCnt_r;
  logic             sysRstn_r;
  logic [2:0]       status_r;
  logic [2:0]       setMask_s;
  logic [2:0]       clrMask_s;
  logic [15:0]      countRd_s;
  logic             inRun_s;
  logic             wrRun_s;
  logic             wdtTrig_s;
  logic             swTrig_s;
  logic             trig_s;
  logic             unusedBits_s;

  reset_sync uSync (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .o_syncRstn (syncRstn_s)
  );

  // Triggers and writes only count in RUN, so a pending hold can never be restarted.
  assign inRun_s      = (state_r == ST_RUN);
  assign wrRun_s      = inRun_s && i_memWrEn;
  assign wdtTrig_s    = inRun_s && i_wdtReset;
  assign swTrig_s     = wrRun_s && (i_memAddr == ADDR_CTRL) && i_memDataIn[CTRL_SW_BIT];
  assign trig_s       = wdtTrig_s || swTrig_s;
  assign unusedBits_s = ^i_memDataIn[15:3];

  // Hold/run state machine with registered reset output.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r   <= ST_HOLD;
      holdCnt_r <= {CNT_W{1'b0}};
      sysRstn_r <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          sysRstn_r <= 1'b0;
          if (!syncRstn_s) begin
            holdCnt_r <= {CNT_W{1'b0}};
          end else if (holdCnt_r == HOLD_LAST) begin
            state_r   <= ST_RUN;
            sysRstn_r <= 1'b1;
            holdCnt_r <= {CNT_W{1'b0}};
          end else begin
            holdCnt_r <= holdCnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (trig_s) begin
            state_r   <= ST_HOLD;
            sysRstn_r <= 1'b0;
            holdCnt_r <= {CNT_W{1'b0}};
          end else begin
            sysRstn_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_HOLD;
          sysRstn_r <= 1'b0;
          holdCnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign o_sysRstn = sysRstn_r;

  // Cause bits to set and W1C bits to clear this cycle.
  always_comb begin
    setMask_s            = 3'b000;
    setMask_s[CAUSE_WDT] = wdtTrig_s;
    setMask_s[CAUSE_SW]  = swTrig_s;
    clrMask_s            = 3'b000;
    if (wrRun_s && (i_memAddr == ADDR_STATUS)) begin
      clrMask_s = i_memDataIn[2:0];
    end else begin
      clrMask_s = 3'b000;
    end
  end

  // Sticky cause register; a set beats a same-cycle clear, and o_sysRstn does not touch it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      status_r <= 3'b001 << CAUSE_POR;
    end else begin
      status_r <= (status_r & ~clrMask_s) | setMask_s;
    end
  end

`ifdef RSTCTRL_WDT_COUNT_EN
  logic [WDT_CNT_W-1:0] wdtCount_r;
  logic                 cntClr_s;

  assign cntClr_s = wrRun_s && (i_memAddr == ADDR_COUNT);

  // Saturating count of watchdog-caused resets; a same-cycle clear restarts it at one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wdtCount_r <= {WDT_CNT_W{1'b0}};
    end else if (wdtTrig_s) begin
      wdtCount_r <= satInc(cntClr_s ? {WDT_CNT_W{1'b0}} : wdtCount_r);
    end else if (cntClr_s) begin
      wdtCount_r <= {WDT_CNT_W{1'b0}};
    end else begin
      wdtCount_r <= wdtCount_r;
    end
  end

  assign countRd_s = {{(16-WDT_CNT_W){1'b0}}, wdtCount_r};
`else
  assign countRd_s = 16'h0000;
`endif

  // Combinational register read mux.
  always_comb begin
    o_memDataOut = 16'h0000;
    case (i_memAddr)
      ADDR_STATUS: o_memDataOut = {13'd0, status_r};
      ADDR_CTRL:   o_memDataOut = 16'h0000;
      ADDR_COUNT:  o_memDataOut = countRd_s;
      default:     o_memDataOut = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl: stimulus queues expected reset-line and
// register values, a negedge monitor pops and compares them.
module tb_reset_ctrl;

  localparam int HOLD = 16;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_wdtReset;
  logic [1:0]  i_memAddr;
  logic [15:0] i_memDataIn;
  logic        i_memWrEn;
  logic [15:0] o_memDataOut;
  logic        o_sysRstn;

  int          nChecks = 0;
  int          nPass   = 0;
  int          kindQ[$];
  logic [15:0] expQ[$];
  string       nameQ[$];

  reset_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_wdtReset   (i_wdtReset),
    .i_memAddr    (i_memAddr),
    .i_memDataIn  (i_memDataIn),
    .i_memWrEn    (i_memWrEn),
    .o_memDataOut (o_memDataOut),
    .o_sysRstn    (o_sysRstn)
  );

  always #5 i_clk = ~i_clk;

`ifdef RSTCTRL_WDT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  function automatic logic [15:0] cnt(input logic [15:0] v);
    return CNT_EN ? v : 16'h0000;
  endfunction

  // Monitor: compares every pending expectation against the DUT at the falling edge.
  always @(negedge i_clk) begin
    while (kindQ.size() > 0) begin
      int          k;
      logic [15:0] e;
      logic [15:0] a;
      string       n;
      k = kindQ.pop_front();
      e = expQ.pop_front();
      n = nameQ.pop_front();
      a = (k == 0) ? {15'd0, o_sysRstn} : o_memDataOut;
      nChecks++;
      if (a === e) nPass++;
      else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  end

  task automatic push(input int kind, input logic [15:0] e, input string n);
    kindQ.push_back(kind);
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e, input string n);
    i_memAddr = a;
    push(1, e, n);
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    i_memAddr   = a;
    i_memDataIn = d;
    i_memWrEn   = 1'b1;
    tick();
    i_memWrEn   = 1'b0;
    i_memDataIn = 16'h0000;
  endtask

  // lowN edges with o_sysRstn low, then one edge where it must be high.
  task automatic rstSeq(input int lowN, input string n);
    for (int i = 0; i < lowN; i++) begin
      tick();
      push(0, 16'h0000, n);
    end
    tick();
    push(0, 16'h0001, {n, "_rise"});
  endtask

  // Watchdog trigger from RUN; optional mid-hold wdt pulse and W1C write that must be ignored.
  task automatic wdtHold(input int wdtAt, input int w1cAt, input string n);
    i_wdtReset = 1'b1;
    tick();
    i_wdtReset = 1'b0;
    push(0, 16'h0000, {n, "_fall"});
    for (int i = 1; i < HOLD; i++) begin
      i_wdtReset  = (i == wdtAt);
      i_memWrEn   = (i == w1cAt);
      i_memAddr   = 2'b00;
      i_memDataIn = (i == w1cAt) ? 16'h0007 : 16'h0000;
      tick();
      push(0, 16'h0000, {n, "_low"});
    end
    i_wdtReset  = 1'b0;
    i_memWrEn   = 1'b0;
    i_memDataIn = 16'h0000;
    tick();
    push(0, 16'h0001, {n, "_rise"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    i_rstn = 1'b0; i_wdtReset = 1'b0; i_memAddr = 2'b00;
    i_memDataIn = 16'h0000; i_memWrEn = 1'b0;

    // Power-on: three cycles in reset, then 2+HOLD edges to release.
    #1;
    push(0, 16'h0000, "por_in_reset");
    rd(2'b00, 16'h0001, "por_status_in_reset");
    tick();
    tick();
    i_rstn = 1'b1;
    rstSeq(HOLD + 1, "por_release");
    rd(2'b00, 16'h0001, "por_status");
    rd(2'b10, 16'h0000, "por_count");
    rd(2'b01, 16'h0000, "ctrl_reads_zero");
    rd(2'b11, 16'h0000, "addr3_reads_zero");

    // Single watchdog reset.
    wdtHold(0, 0, "wdt");
    rd(2'b00, 16'h0003, "wdt_status");
    rd(2'b10, cnt(16'h0001), "wdt_count");

    // Software reset, then W1C of all cause bits.
    wr(2'b01, 16'h0001);
    push(0, 16'h0000, "sw_fall");
    rstSeq(HOLD - 1, "sw_hold");
    rd(2'b00, 16'h0007, "sw_status");
    wr(2'b00, 16'h0007);
    rd(2'b00, 16'h0000, "w1c_status");

    // CTRL write without bit0 does nothing.
    wr(2'b01, 16'hFFFE);
    push(0, 16'h0001, "ctrl_no_bit0");
    rd(2'b00, 16'h0000, "ctrl_no_bit0_status");

    // Same-cycle SW write and watchdog pulse.
    i_wdtReset = 1'b1;
    wr(2'b01, 16'h0001);
    i_wdtReset = 1'b0;
    push(0, 16'h0000, "both_fall");
    rstSeq(HOLD - 1, "both_hold");
    rd(2'b00, 16'h0006, "both_status");
    rd(2'b10, cnt(16'h0002), "both_count");

    // Mid-hold watchdog pulse and W1C write are ignored; the hold is not extended.
    wdtHold(7, 10, "midhold");
    rd(2'b00, 16'h0006, "midhold_status");
    rd(2'b10, cnt(16'h0003), "midhold_count");
    wr(2'b00, 16'h0007);
    rd(2'b00, 16'h0000, "clear_status");

    // Saturation after 257 more watchdog resets, then clear by write.
    for (int r = 0; r < 257; r++) wdtHold(0, 0, "sat");
    rd(2'b10, cnt(16'h00FF), "sat_count");
    rd(2'b00, 16'h0002, "sat_status");
    wr(2'b10, 16'h1234);
    push(0, 16'h0001, "count_wr_no_reset");
    rd(2'b10, 16'h0000, "count_cleared");

    // Async reset at holdCnt=7 restarts the full power-on sequence.
    i_wdtReset = 1'b1;
    tick();
    i_wdtReset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    i_rstn = 1'b0;
    #1;
    push(0, 16'h0000, "async_low");
    rd(2'b00, 16'h0001, "async_status");
    tick();
    i_rstn = 1'b1;
    rstSeq(HOLD + 1, "async_release");
    rd(2'b00, 16'h0001, "async_status_after");
    rd(2'b10, 16'h0000, "async_count_after");

    @(negedge i_clk);
    #1;
    if (kindQ.size() != 0) begin
      nChecks++;
      $display("FAIL drain: got %0d pending, expected 0", kindQ.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
